// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: one DIGIT-bit slice reused over WIDTH/DIGIT cycles, with a registered carry.
// Define ALU_DIGIT_SERIAL_FLAGS_EN to build zero/negative/overflow; otherwise those ports are tied 0.

module alu_digit_serial_bit (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [2:0] op_i,
  output logic       r_o,
  output logic       c_o
);
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic bx;

  always_comb begin
    bx  = (op_i == OP_SUB) ? ~b_i : b_i;
    c_o = (a_i & bx) | (c_i & (a_i ^ bx));
    unique case (op_i)
      OP_ADD, OP_SUB: r_o = a_i ^ bx ^ c_i;
      OP_AND:         r_o = a_i & b_i;
      OP_OR:          r_o = a_i | b_i;
      OP_NOR:         r_o = ~(a_i | b_i);
      OP_XOR:         r_o = a_i ^ b_i;
      default:        r_o = a_i;
    endcase
  end
endmodule

module alu_digit_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dres;
  logic [WIDTH-1:0] acc_next;
  logic             accept, last, is_arith, finish;

  // Ripple chain inside one digit; carry_q links successive digits.
  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    alu_digit_serial_bit u_bit (
      .a_i  (a_q[i]),
      .b_i  (b_q[i]),
      .c_i  (c[i]),
      .op_i (op_q),
      .r_o  (dres[i]),
      .c_o  (c[i+1])
    );
  end

  // LSB digit is produced first, so results shift in from the top.
  assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dres) << (WIDTH - DIGIT));
  assign last     = (cnt_q == LAST);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign finish   = (state_q == S_RUN) && last;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign carryout  = cout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    op_d    = op_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_next;
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          out_d   = acc_next;
          cout_d  = is_arith & c[DIGIT];
        end
      end
      S_DONE: if (out_ready) state_d = in_valid ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      a_d     = A;
      b_d     = B;
      op_d    = control;
      carry_d = (control == OP_ADD) ? carryin : (control == OP_SUB);
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

`ifdef ALU_DIGIT_SERIAL_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  // Overflow is carry-in vs carry-out of the MSB, seen only on the last digit.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    if (finish) begin
      zero_d = (acc_next == '0);
      neg_d  = acc_next[WIDTH-1];
      ovf_d  = is_arith & (c[DIGIT-1] ^ c[DIGIT]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero     = zero_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_digit_serial.sv
// Scoreboard bench for alu_digit_serial (WIDTH=8, DIGIT=2): driver pushes model results, monitor pops on output.
module tb_alu_digit_serial;
  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;
`ifdef ALU_DIGIT_SERIAL_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] o;
    logic co, z, n, v;
    int   acc;
  } exp_t;

  logic clock = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, carryin = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [2:0] control = '0;
  logic in_ready, out_valid, carryout, zero, negative, overflow;
  logic [W-1:0] dout;

  int checks = 0, errors = 0, cyc = 0, ready_mode = 0;
  bit mon_first = 1'b0;
  exp_t q[$];

  alu_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .carryin(carryin), .control(control),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout),
    .carryout(carryout), .zero(zero), .negative(negative), .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on whole words.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [2:0] ctl);
    exp_t e;
    logic [W:0] s;
    e.co = 1'b0; e.v = 1'b0; e.acc = 0;
    case (ctl)
      3'd2: begin
        s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        e.o = s[W-1:0]; e.co = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.o[W-1] != a[W-1]);
      end
      3'd3: begin
        e.o = a - b; e.co = (a >= b);
        e.v = (a[W-1] != b[W-1]) && (e.o[W-1] != a[W-1]);
      end
      3'd4: e.o = a & b;
      3'd5: e.o = a | b;
      3'd6: e.o = ~(a | b);
      3'd7: e.o = a ^ b;
      default: e.o = a;
    endcase
    e.z = FLAGS && (e.o == '0);
    e.n = FLAGS && e.o[W-1];
    e.v = FLAGS && e.v;
    return e;
  endfunction

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: full compare on first valid cycle, hold check after, pop on handshake.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_valid: got out=%0h with no pending op (cycle %0d)", dout, cyc);
      end else begin
        if (!mon_first) begin
          mon_first = 1'b1;
          chk("latency", cyc, q[0].acc + N);
          chk("out", dout, q[0].o);
          chk("carryout", carryout, q[0].co);
          chk("zero", zero, q[0].z);
          chk("negative", negative, q[0].n);
          chk("overflow", overflow, q[0].v);
        end else begin
          chk("out_hold", dout, q[0].o);
        end
        if (!out_ready) chk("in_ready_stall", in_ready, 1'b0);
        else begin
          void'(q.pop_front());
          mon_first = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [2:0] ctl);
    exp_t e;
    int t = 0;
    A = a; B = b; carryin = cin; control = ctl; in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        e = model(a, b, cin, ctl);
        e.acc = cyc + 1;
        q.push_back(e);
        break;
      end
      if (++t > 50) begin
        checks++; errors++;
        $display("FAIL issue_timeout: in_ready low for %0d cycles", t);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; A = W'($urandom); B = W'($urandom); control = 3'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
      q.delete();
    end
    @(posedge clock); #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out", dout, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_carryout", carryout, 1'b0);
    chk("rst_flags", {zero, negative, overflow}, 3'b000);
    chk("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;

    issue(8'h7F, 8'h01, 1'b0, 3'd2); drain();
    issue(8'h05, 8'h05, 1'b0, 3'd3);
    issue(8'h00, 8'h01, 1'b0, 3'd3); drain();
    issue(8'hF0, 8'h0C, 1'b0, 3'd6);
    issue(8'h5A, 8'h33, 1'b1, 3'd0); drain();

    // Backpressure: result held, a one-cycle in_valid pulse must be ignored.
    ready_mode = 2;
    issue(8'h33, 8'h44, 1'b0, 3'd2);
    for (int i = 0; i < 20 && !out_valid; i++) @(posedge clock);
    @(posedge clock); #1;
    A = 8'hFF; B = 8'hFF; control = 3'd7; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock);
    ready_mode = 0;
    drain();

    // Reset in the 2nd RUN cycle aborts the op.
    issue(8'h11, 8'h22, 1'b0, 3'd2);
    @(posedge clock); #2;
    reset_n = 1'b0;
    q.delete(); mon_first = 1'b0;
    #1;
    chk("abort_out", dout, 8'h00);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    issue(8'h10, 8'h20, 1'b0, 3'd2); drain();

    // Back-to-back accept straight out of DONE.
    issue(8'h01, 8'h02, 1'b0, 3'd2);
    issue(8'h03, 8'h04, 1'b1, 3'd2);
    issue(8'h80, 8'h01, 1'b0, 3'd3); drain();

    ready_mode = 1;
    for (int k = 0; k < 60; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 3'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
